// File: rtl/noc_flit_packetizer.sv
// rtl/noc_flit_packetizer.sv - one message in, HEADER/DATA.../TAIL flit stream out
// Optional: NOC_PACKETIZER_FLITCNT_EN places the payload flit count N in the header rem field.
module noc_flit_packetizer #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int MESH_ADDR_X     = 2,
    parameter int MESH_ADDR_Y     = 2,
    parameter int MSG_WIDTH       = 128
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               msg_valid,
    output logic                               msg_ready,
    input  logic [MESH_ADDR_X-1:0]             msg_dst_x,
    input  logic [MESH_ADDR_Y-1:0]             msg_dst_y,
    input  logic [MSG_WIDTH-1:0]               msg_data,
    input  logic [$clog2(MSG_WIDTH+1)-1:0]     msg_len,
    output logic                               flit_valid,
    input  logic                               flit_ready,
    output logic [FLIT_DATA_WIDTH+1:0]         flit_out,
    output logic                               busy
);
    localparam int FDW      = FLIT_DATA_WIDTH;
    localparam int LEN_W    = $clog2(MSG_WIDTH + 1);
    localparam int TLW      = $clog2(FDW + 1);
    localparam int NMAX     = (MSG_WIDTH + FDW - 1) / FDW;
    localparam int CNT_W    = $clog2(NMAX + 1);
    localparam int DW       = NMAX * FDW;
    localparam int HDR_USED = MESH_ADDR_X + MESH_ADDR_Y + TLW;

    localparam logic [1:0] FT_HEADER = 2'd0;
    localparam logic [1:0] FT_DATA   = 2'd1;
    localparam logic [1:0] FT_TAIL   = 2'd2;

    localparam logic [LEN_W-1:0] MSG_W_L = LEN_W'(MSG_WIDTH);

    if (FDW < HDR_USED) begin : g_err_hdr
        $error("noc_flit_packetizer: header fields do not fit in FLIT_DATA_WIDTH");
    end
`ifdef NOC_PACKETIZER_FLITCNT_EN
    if (FDW < HDR_USED + CNT_W) begin : g_err_cnt
        $error("noc_flit_packetizer: header with flit count does not fit in FLIT_DATA_WIDTH");
    end
`endif

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                 state, state_nx;
    logic [DW-1:0]          data_q;
    logic [MESH_ADDR_X-1:0] dst_x_q;
    logic [MESH_ADDR_Y-1:0] dst_y_q;
    logic [TLW-1:0]         t_q;
    logic [CNT_W-1:0]       last_q;
    logic [CNT_W-1:0]       idx;

    logic [LEN_W-1:0]       len_c;
    logic [LEN_W:0]         n_raw;
    logic [CNT_W-1:0]       n_calc;
    logic [CNT_W-1:0]       last_calc;
    logic [LEN_W-1:0]       t_full;
    logic [TLW-1:0]         t_calc;

    // Packet geometry is computed once from the live inputs and latched at acceptance.
    always_comb begin
        len_c     = (msg_len > MSG_W_L) ? MSG_W_L : msg_len;
        n_raw     = ({1'b0, len_c} + (LEN_W+1)'(FDW - 1)) / (LEN_W+1)'(FDW);
        n_calc    = (n_raw == '0) ? CNT_W'(1) : CNT_W'(n_raw);
        last_calc = n_calc - CNT_W'(1);
        t_full    = len_c - LEN_W'(int'(last_calc) * FDW);
        t_calc    = TLW'(t_full);
    end

    logic [FDW-1:0] hdr_payload;
    logic [FDW-1:0] body_payload;
    logic [FDW-1:0] tail_mask;
    logic           at_last;

    always_comb begin
        hdr_payload = '0;
        hdr_payload[FDW-1 -: MESH_ADDR_X]               = dst_x_q;
        hdr_payload[FDW-1-MESH_ADDR_X -: MESH_ADDR_Y]   = dst_y_q;
        hdr_payload[FDW-1-MESH_ADDR_X-MESH_ADDR_Y -: TLW] = t_q;
`ifdef NOC_PACKETIZER_FLITCNT_EN
        hdr_payload[FDW-1-HDR_USED -: CNT_W] = last_q + CNT_W'(1);
`endif
        for (int b = 0; b < FDW; b++) begin
            tail_mask[b] = (b < int'(t_q));
        end
        at_last      = (idx == last_q);
        body_payload = data_q[int'(idx)*FDW +: FDW];
        if (at_last) begin
            body_payload = body_payload & tail_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
            t_q     <= '0;
            last_q  <= '0;
            idx     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && msg_valid) begin
                data_q  <= DW'(msg_data);
                dst_x_q <= msg_dst_x;
                dst_y_q <= msg_dst_y;
                t_q     <= t_calc;
                last_q  <= last_calc;
                idx     <= '0;
            end else if (state == BODY && flit_ready && !at_last) begin
                idx <= idx + CNT_W'(1);
            end
        end
    end

    // Outputs decode from registered state only, so a stalled flit stays stable.
    always_comb begin
        state_nx   = state;
        msg_ready  = 1'b0;
        flit_valid = 1'b0;
        flit_out   = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) state_nx = HDR;
            end
            HDR: begin
                flit_valid = 1'b1;
                flit_out   = {FT_HEADER, hdr_payload};
                if (flit_ready) state_nx = BODY;
            end
            BODY: begin
                flit_valid = 1'b1;
                flit_out   = {at_last ? FT_TAIL : FT_DATA, body_payload};
                if (flit_ready && at_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_noc_flit_packetizer.sv
// tb/tb_noc_flit_packetizer.sv - randomized bench with reference flit model
module tb_noc_flit_packetizer;
    localparam int FDW = 16;
    localparam int MW  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_dst_x;
    logic [1:0]  msg_dst_y;
    logic [63:0] msg_data;
    logic [6:0]  msg_len;
    logic        flit_valid;
    logic        flit_ready;
    logic [17:0] flit_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];
    logic [17:0] last_hdr;

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
`ifdef NOC_PACKETIZER_FLITCNT_EN
    localparam logic [17:0] HDR1 = 18'h06430;
`else
    localparam logic [17:0] HDR1 = 18'h06400;
`endif

    noc_flit_packetizer #(
        .FLIT_DATA_WIDTH(FDW), .MESH_ADDR_X(2), .MESH_ADDR_Y(2), .MSG_WIDTH(MW)
    ) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_dst_x(msg_dst_x), .msg_dst_y(msg_dst_y), .msg_data(msg_data),
        .msg_len(msg_len), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_out(flit_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic build_expected(input logic [1:0] dx, input logic [1:0] dy,
                                  input int len, input logic [63:0] data);
        int l, n, t;
        logic [15:0] hdr;
        logic [15:0] p;
        l = (len > MW) ? MW : len;
        n = (l + FDW - 1) / FDW;
        if (n == 0) n = 1;
        t = l - (n - 1) * FDW;
        hdr = {dx, dy, 5'(t), 7'd0};
`ifdef NOC_PACKETIZER_FLITCNT_EN
        hdr[6:4] = 3'(n);
`endif
        exp_q.delete();
        exp_q.push_back({2'd0, hdr});
        for (int i = 0; i < n; i++) begin
            p = 16'(data >> (FDW * i));
            if (i == n - 1) begin
                p = p & 16'((32'd1 << t) - 32'd1);
                exp_q.push_back({2'd2, p});
            end else begin
                exp_q.push_back({2'd1, p});
            end
        end
    endtask

    task automatic send(input logic [1:0] dx, input logic [1:0] dy, input int len,
                        input logic [63:0] data, input bit rand_rdy,
                        input int stall_at, input int stall_len);
        int w, consumed, stalled, cyc;
        bit was_stall;
        logic [17:0] held;
        build_expected(dx, dy, len, data);
        w = 0;
        while (!msg_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("msg_ready_idle", msg_ready, 1);
        msg_valid = 1'b1; msg_dst_x = dx; msg_dst_y = dy;
        msg_data = data; msg_len = 7'(len); flit_ready = 1'b0;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_dst_x = 2'($urandom); msg_dst_y = 2'($urandom);
        msg_data = {$urandom, $urandom}; msg_len = 7'($urandom);
        check("hdr_latency", flit_valid, 1);
        check("busy_pkt", busy, 1);
        check("msg_ready_pkt", msg_ready, 0);
        consumed = 0; stalled = 0; cyc = 0; was_stall = 1'b0; held = '0;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (was_stall) begin
                check("stall_valid", flit_valid, 1);
                check("stall_hold", flit_out, held);
            end
            if (flit_valid) begin
                if (consumed == stall_at && stalled < stall_len) begin
                    flit_ready = 1'b0;
                    stalled++;
                end else begin
                    flit_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (flit_ready) begin
                    if (consumed == 0) last_hdr = flit_out;
                    check("flit", flit_out, exp_q.pop_front());
                    consumed++;
                    was_stall = 1'b0;
                end else begin
                    was_stall = 1'b1;
                    held = flit_out;
                end
            end else begin
                check("flit_valid_drop", flit_valid, 1);
                flit_ready = 1'b0;
                was_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        flit_ready = 1'b0;
        check("pkt_timeout", exp_q.size(), 0);
        check("bubble_ready", msg_ready, 1);
        check("bubble_busy", busy, 0);
        check("bubble_valid", flit_valid, 0);
    endtask

    initial begin
        rst = 1'b1; msg_valid = 1'b0; msg_dst_x = '0; msg_dst_y = '0;
        msg_data = '0; msg_len = '0; flit_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_msg_ready", msg_ready, 1);
        check("rst_flit_valid", flit_valid, 0);
        check("rst_flit_out", flit_out, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        send(2'd1, 2'd2, 40, D0, 1'b0, -1, 0);
        check("t1_header", last_hdr, HDR1);
        send(2'd0, 2'd3, 16, D0, 1'b0, -1, 0);
        send(2'd1, 2'd2, 40, D0, 1'b0, 1, 3);

        // Reset while the second DATA flit is on the output.
        msg_valid = 1'b1; msg_dst_x = 2'd1; msg_dst_y = 2'd2; msg_data = D0; msg_len = 7'd40;
        @(negedge clk);
        msg_valid = 1'b0; flit_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_data1", flit_out, {2'd1, 16'h89AB});
        rst = 1'b1;
        #1;
        check("rst_mid_valid", flit_valid, 0);
        @(negedge clk);
        rst = 1'b0; flit_ready = 1'b0;
        check("rst_mid_ready", msg_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_out", flit_out, 0);
        send(2'd0, 2'd0, 8, D0, 1'b0, -1, 0);

        send(2'd3, 2'd1, 0, D0, 1'b0, -1, 0);
        send(2'd2, 2'd2, 70, D0, 1'b0, -1, 0);

        for (int k = 0; k < 40; k++) begin
            send(2'($urandom), 2'($urandom), int'($urandom_range(0, 127)),
                 {$urandom, $urandom}, 1'b1, int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
